// File: rtl/sparse_pkg.sv
// Shared types for the sparse row scheduler: the 2:4 sparse weight packet,
// the four-wide activation group, the scheduler state encoding and the
// PE partial-sum width.
package sparse_pkg;

    localparam int PSUM_W = 20;
    localparam int VAL_W  = 8;
    localparam int ACT_W  = 8;

    // Two kept weights of a 2:4 group plus the lane each one multiplies.
    typedef struct packed {
        logic [VAL_W-1:0] val1;
        logic [VAL_W-1:0] val0;
        logic [1:0]       idx1;
        logic [1:0]       idx0;
    } sparse_packet_t;

    typedef logic [3:0][ACT_W-1:0] activation_vec_t;

    localparam int PKT_W = $bits(sparse_packet_t);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        OUT,
        DONE
    } state_t;

endpackage

// File: rtl/sparse_row_scheduler_if.sv
// Bundle of job control, memory read, PE and row-result signals between the
// scheduler (master) and its SRAMs / PE / consumer (slave).
interface sparse_row_scheduler_if #(
    parameter int AW    = 10,
    parameter int ACC_W = 32
);
    import sparse_pkg::*;

    logic                     start;
    logic [15:0]              num_rows;
    logic [7:0]               groups;
    logic [AW-1:0]            w_base;
    logic                     busy;
    logic                     done;

    logic                     w_rd_en;
    logic [AW-1:0]            w_addr;
    sparse_packet_t           w_rdata;
    logic                     a_rd_en;
    logic [AW-1:0]            a_addr;
    activation_vec_t          a_rdata;

    logic                     pe_en;
    sparse_packet_t           pe_pkt;
    activation_vec_t          pe_act;
    logic signed [PSUM_W-1:0] pe_psum;

    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  out_data;
    logic [15:0]              out_row;

    modport master (
        input  start, num_rows, groups, w_base, w_rdata, a_rdata, pe_psum, out_ready,
        output busy, done, w_rd_en, w_addr, a_rd_en, a_addr,
               pe_en, pe_pkt, pe_act, out_valid, out_data, out_row
    );

    modport slave (
        output start, num_rows, groups, w_base, w_rdata, a_rdata, pe_psum, out_ready,
        input  busy, done, w_rd_en, w_addr, a_rd_en, a_addr,
               pe_en, pe_pkt, pe_act, out_valid, out_data, out_row
    );

endinterface

// File: rtl/psum_delay_line.sv
// Valid-token shift register that marks the cycle a PE partial sum arrives,
// DEPTH cycles after the matching pe_en. early_busy flags tokens still in the
// stages ahead of the output.
module psum_delay_line #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic tok_in,
    output logic tok_out,
    output logic early_busy
);

    logic [DEPTH-1:0] stages;

    // Shift the token one stage per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stages <= '0;
        end else begin
            stages[0] <= tok_in;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    // Any token not yet at the output stage.
    always_comb begin
        early_busy = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            early_busy = early_busy | stages[i];
        end
    end

    assign tok_out = stages[DEPTH-1];

endmodule

// File: rtl/sparse_row_scheduler.sv
// Walks one sparse PE across a 2:4-sparse matrix-vector product: per row it
// streams GROUPS packet/activation reads, forwards the read data to the PE,
// accumulates the returning partial sums and offers the row total on a
// valid/ready port.
module sparse_row_scheduler
    import sparse_pkg::*;
#(
    parameter int AW     = 10,
    parameter int ACC_W  = 32,
    parameter int PE_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    sparse_row_scheduler_if.master bus
);

    state_t                  state, state_nx;
    logic [15:0]             rows_q, row_q;
    logic [7:0]              groups_q, g_q;
    logic [AW-1:0]           w_ptr;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] psum_ext;
    logic                    rd_q, pe_en_q;
    sparse_packet_t          pkt_q;
    activation_vec_t         act_q;
    logic                    tok_out, tok_early;
    logic                    issue, last_g, last_row, job_start, next_row;

    assign issue     = (state == ISSUE);
    assign last_g    = (g_q + 8'd1 == groups_q);
    assign last_row  = (row_q + 16'd1 == rows_q);
    assign job_start = (state == IDLE) && bus.start;
    assign next_row  = (state == OUT) && bus.out_ready && !last_row;
    // Sign-extends (or truncates, for narrow accumulators) the PE sum.
    assign psum_ext  = ACC_W'(bus.pe_psum);

    psum_delay_line #(.DEPTH(PE_LAT)) u_delay (
        .clk        (clk),
        .rst        (rst),
        .tok_in     (pe_en_q),
        .tok_out    (tok_out),
        .early_busy (tok_early)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state decode.
    // NOTE: the default assignment first keeps this combinational block latch-free.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.start) begin
                if (bus.num_rows == 16'd0)    state_nx = DONE;
                else if (bus.groups == 8'd0)  state_nx = OUT;
                else                          state_nx = ISSUE;
            end
            ISSUE: if (last_g) state_nx = DRAIN;
            // Leave only once no read, PE slot or delayed token is outstanding.
            DRAIN: if (!rd_q && !pe_en_q && !tok_early) state_nx = OUT;
            OUT: if (bus.out_ready) begin
                if (last_row)                 state_nx = DONE;
                else if (groups_q == 8'd0)    state_nx = OUT;
                else                          state_nx = ISSUE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Job parameters, address/group/row counters, PE pipeline and accumulator.
    // NOTE: the PE data registers are reset too, so every output reads 0 while rst is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rows_q   <= '0;
            row_q    <= '0;
            groups_q <= '0;
            g_q      <= '0;
            w_ptr    <= '0;
            acc      <= '0;
            rd_q     <= 1'b0;
            pe_en_q  <= 1'b0;
            pkt_q    <= '0;
            act_q    <= '0;
        end else begin
            rd_q    <= issue;
            pe_en_q <= rd_q;
            if (rd_q) begin
                pkt_q <= bus.w_rdata;
                act_q <= bus.a_rdata;
            end

            if (job_start) begin
                rows_q   <= bus.num_rows;
                groups_q <= bus.groups;
                w_ptr    <= bus.w_base;
                row_q    <= '0;
                g_q      <= '0;
            end else if (issue) begin
                // Packets are laid out row-major, so one running pointer covers all rows.
                w_ptr <= w_ptr + AW'(1);
                g_q   <= last_g ? 8'd0 : g_q + 8'd1;
            end else if (next_row) begin
                row_q <= row_q + 16'd1;
            end

            if (job_start || next_row) acc <= '0;
            else if (tok_out)          acc <= acc + psum_ext;
        end
    end

    assign bus.busy      = (state == ISSUE) || (state == DRAIN) || (state == OUT);
    assign bus.done      = (state == DONE);
    assign bus.w_rd_en   = issue;
    assign bus.a_rd_en   = issue;
    assign bus.w_addr    = w_ptr;
    assign bus.a_addr    = AW'(g_q);
    assign bus.pe_en     = pe_en_q;
    assign bus.pe_pkt    = pkt_q;
    assign bus.pe_act    = act_q;
    assign bus.out_valid = (state == OUT);
    assign bus.out_data  = acc;
    assign bus.out_row   = row_q;

endmodule
